// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Word written into every address the program image does not cover.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Default instruction memory depth in 32-bit words.
  localparam int DEFAULT_DEPTH_WORDS = 256;

  // Bit offset of the low end of byte lane b in a big-endian word.
  function automatic int lane_lsb(input int b);
    return 24 - 8 * b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// master: the side feeding bytes and receiving writes.
// slave:  the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted program bytes big-endian into 32-bit words. A completed
// word (four bytes, or fewer when in_last arrives) is presented with a
// one-cycle word_valid pulse on the cycle after its final byte. Lanes not
// yet filled are always zero, so a short final word comes out zero-padded.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        accept,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic [31:0] word_data,
  output logic        word_valid,
  output logic        word_last,
  output logic        word_partial
);

  logic [31:0] asm_reg;
  logic [1:0]  idx_reg;
  logic [31:0] word_reg;
  logic        valid_reg;
  logic        last_reg;
  logic        partial_reg;
  logic [31:0] merged;
  logic        complete;

  // Each lane takes the incoming byte when it is the current byte index,
  // otherwise keeps what has been assembled so far.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[lane_lsb(gi) +: 8] =
      (idx_reg == 2'(gi)) ? in_data : asm_reg[lane_lsb(gi) +: 8];
  end

  assign complete = accept && ((idx_reg == 2'd3) || in_last);

  // Assembly register, byte index and the registered completed word.
  always_ff @(posedge clk) begin
    if (srst) begin
      asm_reg     <= '0;
      idx_reg     <= '0;
      word_reg    <= '0;
      valid_reg   <= 1'b0;
      last_reg    <= 1'b0;
      partial_reg <= 1'b0;
    end else begin
      valid_reg <= complete;
      if (accept) begin
        if (complete) begin
          word_reg    <= merged;
          last_reg    <= in_last;
          partial_reg <= in_last && (idx_reg != 2'd3);
          asm_reg     <= '0;
          idx_reg     <= '0;
        end else begin
          asm_reg <= merged;
          idx_reg <= idx_reg + 2'd1;
        end
      end
    end
  end

  assign word_data    = word_reg;
  assign word_valid   = valid_reg;
  assign word_last    = last_reg;
  assign word_partial = partial_reg;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: streams a byte image into the
// instruction memory, pads the rest with NOPs and releases the CPU.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              startin,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic                error_reg, error_next;
  logic                wr_en_int;
  logic [31:0]         wr_data_int;
  logic                in_ready_int;
  logic                accept;
  logic                final_pending;

  logic [31:0]         word_data;
  logic                word_valid;
  logic                word_last;
  logic                word_partial;

  assign accept = bus.in_valid && in_ready_int;

  word_assembler u_asm (
    .clk          (clk),
    .srst         (startin),
    .accept       (accept),
    .in_data      (bus.in_data),
    .in_last      (bus.in_last),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_last    (word_last),
    .word_partial (word_partial)
  );

  // A word being written that ends the image (in_last or top address)
  // closes the byte stream right away, so nothing past it is taken in.
  assign final_pending = word_valid && (word_last || (addr_reg == LAST_ADDR));

  // Ready only while collecting the image.
  always_comb begin
    in_ready_int = 1'b0;
    if ((state_reg == ST_IDLE) || (state_reg == ST_LOAD)) begin
      in_ready_int = !final_pending;
    end
  end

  // Next-state, address, counters and write strobe.
  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    count_next  = count_reg;
    error_next  = error_reg;
    wr_en_int   = 1'b0;
    wr_data_int = word_data;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (word_valid) begin
          wr_en_int  = 1'b1;
          count_next = count_reg + CNT_ONE;
          if (word_partial) begin
            error_next = 1'b1;
          end
          if (addr_reg == LAST_ADDR) begin
            // Top word: either the image fits exactly or it overflowed.
            state_next = ST_DONE;
            if (!word_last) begin
              error_next = 1'b1;
            end
          end else begin
            addr_next = addr_reg + ADDR_ONE;
            if (word_last) begin
              state_next = ST_CLEAR;
            end
          end
        end
      end
      ST_CLEAR: begin
        wr_en_int   = 1'b1;
        wr_data_int = NOP_WORD;
        if (addr_reg == LAST_ADDR) begin
          state_next = ST_DONE;
        end else begin
          addr_next = addr_reg + ADDR_ONE;
        end
      end
      default: begin
        state_next = ST_DONE;
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (startin) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      count_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      count_reg <= count_next;
      error_reg <= error_next;
    end
  end

  assign bus.in_ready = in_ready_int;
  assign bus.wr_en    = wr_en_int;
  assign bus.wr_addr  = addr_reg;
  assign bus.wr_data  = wr_data_int;
  assign cpu_hold     = (state_reg != ST_DONE);
  assign done         = (state_reg == ST_DONE);
  assign word_count   = count_reg;
  assign error        = error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 256-word instance for the normal
// flows and a 4-word instance for overflow.
module tb_imem_loader;

  logic       clk;
  logic       rst_a, rst_b;
  logic       hold_a, done_a, err_a;
  logic [8:0] cnt_a;
  logic       hold_b, done_b, err_b;
  logic [2:0] cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  int wa_a[$];
  logic [31:0] wd_a[$];
  int wa_b[$];
  logic [31:0] wd_b[$];
  int hold_bad_a = 0;

  imem_loader_if #(.ADDR_W(8)) ifa ();
  imem_loader_if #(.ADDR_W(2)) ifb ();

  imem_loader #(.DEPTH_WORDS(256), .ADDR_W(8)) dut_a (
    .clk(clk), .startin(rst_a), .bus(ifa),
    .cpu_hold(hold_a), .done(done_a), .word_count(cnt_a), .error(err_a)
  );

  imem_loader #(.DEPTH_WORDS(4), .ADDR_W(2)) dut_b (
    .clk(clk), .startin(rst_b), .bus(ifb),
    .cpu_hold(hold_b), .done(done_b), .word_count(cnt_b), .error(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log and cpu_hold/done consistency, sampled mid-cycle.
  always @(negedge clk) begin
    if (ifa.wr_en === 1'b1) begin
      wa_a.push_back(int'(ifa.wr_addr));
      wd_a.push_back(ifa.wr_data);
    end
    if (ifb.wr_en === 1'b1) begin
      wa_b.push_back(int'(ifb.wr_addr));
      wd_b.push_back(ifb.wr_data);
    end
    if (hold_a === done_a) hold_bad_a++;
  end

  task automatic apply_reset(input bit sel);
    if (!sel) begin rst_a = 1'b1; ifa.in_valid = 1'b0; ifa.in_last = 1'b0; end
    else      begin rst_b = 1'b1; ifb.in_valid = 1'b0; ifb.in_last = 1'b0; end
    repeat (2) @(negedge clk);
    if (!sel) rst_a = 1'b0; else rst_b = 1'b0;
  endtask

  // Present one byte and return on the negedge after it was accepted.
  task automatic send(input bit sel, input logic [7:0] d, input bit last);
    int guard;
    guard = 0;
    if (!sel) begin ifa.in_valid = 1'b1; ifa.in_data = d; ifa.in_last = last; end
    else      begin ifb.in_valid = 1'b1; ifb.in_data = d; ifb.in_last = last; end
    while (((!sel) ? (ifa.in_ready !== 1'b1) : (ifb.in_ready !== 1'b1)) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: byte %02h not accepted in %0d cycles, expected acceptance", d, guard);
    end
    @(negedge clk);
    if (!sel) begin ifa.in_valid = 1'b0; ifa.in_last = 1'b0; end
    else      begin ifb.in_valid = 1'b0; ifb.in_last = 1'b0; end
  endtask

  task automatic wait_done(input bit sel, input int limit);
    int k;
    k = 0;
    while (((!sel) ? (done_a !== 1'b1) : (done_b !== 1'b1)) && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (k >= limit) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: done still 0 after %0d cycles, expected 1", k);
    end
  endtask

  task automatic test_reset;
    apply_reset(0);
    n_cmp++; if (ifa.wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en: got %b want 0", ifa.wr_en); end
    n_cmp++; if (ifa.wr_addr !== 8'd0) begin n_bad++; $display("FAIL rst_wr_addr: got %0d want 0", ifa.wr_addr); end
    n_cmp++; if (ifa.wr_data !== 32'd0) begin n_bad++; $display("FAIL rst_wr_data: got %08h want 0", ifa.wr_data); end
    n_cmp++; if (cnt_a !== 9'd0) begin n_bad++; $display("FAIL rst_word_count: got %0d want 0", cnt_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", err_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done_a); end
    n_cmp++; if (hold_a !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_hold: got %b want 1", hold_a); end
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", ifa.in_ready); end
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_basic;
    logic [7:0] b [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    int s, n, bad;
    apply_reset(0);
    s = wa_a.size();
    for (int i = 0; i < 8; i++) send(0, b[i], i == 7);
    wait_done(0, 400);
    n = wa_a.size() - s;
    n_cmp++; if (n != 256) begin n_bad++; $display("FAIL basic_writes: got %0d want 256", n); end
    if (n >= 2) begin
      n_cmp++; if (wa_a[s] != 0 || wd_a[s] !== 32'h20080005) begin n_bad++; $display("FAIL basic_w0: got @%0d %08h want @0 20080005", wa_a[s], wd_a[s]); end
      n_cmp++; if (wa_a[s+1] != 1 || wd_a[s+1] !== 32'h0) begin n_bad++; $display("FAIL basic_w1: got @%0d %08h want @1 00000000", wa_a[s+1], wd_a[s+1]); end
    end
    bad = 0;
    for (int k = 2; k < n; k++) if (wa_a[s+k] != k || wd_a[s+k] !== 32'h0) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL basic_clear: got %0d bad NOP writes want 0", bad); end
    n_cmp++; if (cnt_a !== 9'd2) begin n_bad++; $display("FAIL basic_count: got %0d want 2", cnt_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL basic_error: got %b want 0", err_a); end
    n_cmp++; if (ifa.in_ready !== 1'b0 || hold_a !== 1'b0) begin n_bad++; $display("FAIL basic_done_outs: got ready=%b hold=%b want 0 0", ifa.in_ready, hold_a); end
    $display("test_basic: %0d writes, word_count=%0d error=%b", n, cnt_a, err_a);
  endtask

  task automatic test_partial;
    logic [7:0] b [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
    int s, n;
    apply_reset(0);
    s = wa_a.size();
    for (int i = 0; i < 5; i++) send(0, b[i], i == 4);
    wait_done(0, 400);
    n = wa_a.size() - s;
    n_cmp++; if (n != 256) begin n_bad++; $display("FAIL partial_writes: got %0d want 256", n); end
    if (n >= 2) begin
      n_cmp++; if (wd_a[s] !== 32'h01020304) begin n_bad++; $display("FAIL partial_w0: got %08h want 01020304", wd_a[s]); end
      n_cmp++; if (wa_a[s+1] != 1 || wd_a[s+1] !== 32'hAA000000) begin n_bad++; $display("FAIL partial_w1: got @%0d %08h want @1 AA000000", wa_a[s+1], wd_a[s+1]); end
    end
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL partial_error: got %b want 1", err_a); end
    n_cmp++; if (cnt_a !== 9'd2) begin n_bad++; $display("FAIL partial_count: got %0d want 2", cnt_a); end
    $display("test_partial: %0d writes, word_count=%0d error=%b", n, cnt_a, err_a);
  endtask

  task automatic test_three_words(input int gap, input string tag);
    logic [7:0] b [12] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                           8'h12, 8'h34, 8'h56, 8'h78};
    logic [31:0] w [3] = '{32'h20080005, 32'hDEADBEEF, 32'h12345678};
    int s, n, bad, prog;
    apply_reset(0);
    s = wa_a.size();
    for (int i = 0; i < 12; i++) begin
      send(0, b[i], i == 11);
      repeat (gap) @(negedge clk);
    end
    wait_done(0, 400);
    n = wa_a.size() - s;
    bad = 0;
    prog = 0;
    for (int k = 0; k < n; k++) begin
      if (wa_a[s+k] != k) bad++;
      if (k < 3) begin
        prog++;
        if (wd_a[s+k] !== w[k]) bad++;
      end else if (wd_a[s+k] !== 32'h0) bad++;
    end
    n_cmp++; if (n != 256) begin n_bad++; $display("FAIL %s_writes: got %0d want 256", tag, n); end
    n_cmp++; if (prog != 3) begin n_bad++; $display("FAIL %s_prog_writes: got %0d want 3", tag, prog); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL %s_data: got %0d wrong writes want 0", tag, bad); end
    n_cmp++; if (cnt_a !== 9'd3 || err_a !== 1'b0) begin n_bad++; $display("FAIL %s_status: got count=%0d error=%b want 3 0", tag, cnt_a, err_a); end
    $display("%s: %0d writes, word_count=%0d", tag, n, cnt_a);
  endtask

  task automatic test_overflow;
    int s, n, bad, rdy_bad;
    logic [7:0] base;
    logic [31:0] exp;
    apply_reset(1);
    n_cmp++; if (ifb.in_ready !== 1'b1 || cnt_b !== 3'd0) begin n_bad++; $display("FAIL ovf_reset: got ready=%b count=%0d want 1 0", ifb.in_ready, cnt_b); end
    s = wa_b.size();
    for (int i = 0; i < 16; i++) send(1, 8'(8'h10 + i), 1'b0);
    ifb.in_valid = 1'b1;
    ifb.in_data  = 8'hEE;
    rdy_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifb.in_ready !== 1'b0) rdy_bad++;
    end
    ifb.in_valid = 1'b0;
    n = wa_b.size() - s;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      base = 8'(8'h10 + 4 * k);
      exp  = {base, base + 8'd1, base + 8'd2, base + 8'd3};
      if (wa_b[s+k] != k || wd_b[s+k] !== exp) bad++;
    end
    n_cmp++; if (n != 4) begin n_bad++; $display("FAIL ovf_writes: got %0d want 4", n); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL ovf_data: got %0d wrong writes want 0", bad); end
    n_cmp++; if (rdy_bad != 0) begin n_bad++; $display("FAIL ovf_in_ready: got %0d cycles ready want 0", rdy_bad); end
    n_cmp++; if (err_b !== 1'b1 || done_b !== 1'b1) begin n_bad++; $display("FAIL ovf_status: got error=%b done=%b want 1 1", err_b, done_b); end
    n_cmp++; if (cnt_b !== 3'd4) begin n_bad++; $display("FAIL ovf_count: got %0d want 4", cnt_b); end
    $display("test_overflow: %0d writes, error=%b done=%b", n, err_b, done_b);
  endtask

  task automatic test_reset_abort;
    logic [7:0] b [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    int s, s2, n, h0;
    apply_reset(0);
    h0 = hold_bad_a;
    s = wa_a.size();
    for (int i = 0; i < 6; i++) send(0, b[i], 1'b0);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    n = wa_a.size() - s;
    n_cmp++; if (n != 1 || wd_a[s] !== 32'hAABBCCDD) begin n_bad++; $display("FAIL abort_pre: got %0d writes first %08h want 1 AABBCCDD", n, wd_a[s]); end
    n_cmp++; if (ifa.wr_en !== 1'b0 || ifa.wr_addr !== 8'd0 || cnt_a !== 9'd0) begin n_bad++; $display("FAIL abort_after: got wr_en=%b addr=%0d count=%0d want 0 0 0", ifa.wr_en, ifa.wr_addr, cnt_a); end
    // Reset on the same edge that would complete a word.
    for (int i = 0; i < 3; i++) send(0, 8'(8'h5A + i), 1'b0);
    ifa.in_valid = 1'b1; ifa.in_data = 8'h5D; rst_a = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0; rst_a = 1'b0;
    n_cmp++; if (ifa.wr_en !== 1'b0) begin n_bad++; $display("FAIL abort_pending: got wr_en=%b want 0", ifa.wr_en); end
    @(negedge clk);
    n_cmp++; if (wa_a.size() - s != 1) begin n_bad++; $display("FAIL abort_no_write: got %0d writes want 1", wa_a.size() - s); end
    s2 = wa_a.size();
    for (int i = 0; i < 4; i++) send(0, 8'(i + 1), i == 3);
    wait_done(0, 400);
    n = wa_a.size() - s2;
    n_cmp++; if (n < 1 || wa_a[s2] != 0 || wd_a[s2] !== 32'h01020304) begin n_bad++; $display("FAIL abort_fresh: got %0d writes first %08h want @0 01020304", n, (n > 0) ? wd_a[s2] : 32'hx); end
    n_cmp++; if (cnt_a !== 9'd1 || err_a !== 1'b0) begin n_bad++; $display("FAIL abort_status: got count=%0d error=%b want 1 0", cnt_a, err_a); end
    n_cmp++; if (hold_bad_a != h0) begin n_bad++; $display("FAIL abort_cpu_hold: got %0d bad cycles want 0", hold_bad_a - h0); end
    $display("test_reset_abort: fresh load wrote %0d words", n);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_data = 8'h00; ifa.in_last = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = 8'h00; ifb.in_last = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_partial();
    test_three_words(0, "test_back_to_back");
    test_three_words(2, "test_gapped");
    test_overflow();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, instruction memory depth in 32-bit words; power of two, 4..4096.
REQ-002 Parameter ADDR_W, default 8, word-address width; SHALL equal log2(DEPTH_WORDS).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port startin  input  1  reset, synchronous and active-high.
REQ-005 Port in_valid  input  1  loader byte-stream valid.
REQ-006 Port in_data  input  8  program byte; big-endian, first byte is instr[31:24].
REQ-007 Port in_last  input  1  qualifies in_data as the final program byte.
REQ-008 Port in_ready  output  1  loader can accept a byte; transfer occurs when in_valid & in_ready.
REQ-009 Port wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 Port wr_addr  output  ADDR_W  word address of the write.
REQ-011 Port wr_data  output  32  instruction word written.
REQ-012 Port cpu_hold  output  1  holds the CPU pipeline in reset while high.
REQ-013 Port done  output  1  image complete; level, held until startin.
REQ-014 Port word_count  output  ADDR_W+1  number of program words written, padding words excluded.
REQ-015 Port error  output  1  sticky flag for overflow or a partial final word.

Function
REQ-016 States SHALL be IDLE, LOAD, CLEAR, DONE.
REQ-017 in_ready SHALL be 1 in IDLE and LOAD, and 0 in CLEAR and DONE.
REQ-018 IDLE SHALL move to LOAD on the first accepted byte; that byte SHALL count as byte 0 of word 0.
REQ-019 Each accepted byte SHALL shift into the assembly register; byte index b (0..3) SHALL land in bits [31-8b:24-8b].
REQ-020 On acceptance of byte index 3, wr_en SHALL assert on the next cycle with the assembled word and current address; the address SHALL then increment.
REQ-021 Bytes accepted in the same cycle as a wr_en pulse SHALL go to the next word without loss; sustained one byte per cycle SHALL be supported.
REQ-022 If in_last arrives with byte index < 3, the remaining low bytes SHALL be zero-filled, the word SHALL be written next cycle, and error SHALL be set.
REQ-023 After the in_last word is written, the FSM SHALL enter CLEAR if wr_addr < DEPTH_WORDS-1, otherwise DONE.
REQ-024 CLEAR SHALL write 32'h00000000 (NOP) to each remaining address, one per cycle, through DEPTH_WORDS-1, then enter DONE.
REQ-025 Overflow: when word DEPTH_WORDS-1 completes without in_last, the FSM SHALL write it, set error, and enter DONE; no further bytes are accepted.
REQ-026 word_count SHALL increment with each wr_en in LOAD, including a padded final word, and SHALL NOT increment in CLEAR.
REQ-027 cpu_hold SHALL be 1 in IDLE, LOAD and CLEAR, and 0 only in DONE.
REQ-028 done SHALL equal (state == DONE).
REQ-029 in_valid with in_ready low SHALL be ignored.

Reset
REQ-030 With startin high at a clock edge, the next state SHALL be IDLE, with wr_en=0, wr_addr=0, wr_data=0, word_count=0, error=0, done=0, cpu_hold=1, in_ready=1, and the assembly register and byte index cleared.
REQ-031 A reset asserted in mid-LOAD or mid-CLEAR SHALL abort the load immediately and write nothing on the following cycle.

Structure
REQ-032 A shared package SHALL hold the state enum, the NOP constant (32'h00000000), and the default DEPTH_WORDS.
REQ-033 Byte-to-word assembly SHALL be one sub-module, word_assembler, which outputs the word and a word_valid pulse.

Verification
REQ-034 Stream 8 bytes 20 08 00 05 00 00 00 00 with in_last on the 8th -> wr_en at addr 0 = 32'h20080005, addr 1 = 32'h00000000; NOP writes to addrs 2..255; done=1, word_count=2, error=0.
REQ-035 Stream 5 bytes 01 02 03 04 AA with last on AA -> addr 0 = 32'h01020304, addr 1 = 32'hAA000000; error=1, word_count=2.
REQ-036 DEPTH_WORDS=4, stream 20 bytes without last -> 4 writes, addrs 0..3; error=1, done=1; in_ready=0 from then on; the 17th byte is never written.
REQ-037 Gapped in_valid (1 cycle on, 2 off) across 3 words -> same words as the gapless run; wr_en count=3 before CLEAR.
REQ-038 startin pulsed after the 6th byte -> no wr_en on the next cycle; a fresh 4-byte stream then writes addr 0; cpu_hold stays 1 until DONE.
